// File: rtl/cbs_egress_shaper.sv
// 802.1Qav credit-based egress shaper: SR classes A/B wait for non-negative credit, other classes pass.
// Define CBS_STATS_EN to add the per-class HOLD-cycle counters stall_cycles_a/stall_cycles_b.
module cbs_egress_shaper #(
    parameter logic [2:0] CLASS_A_TDEST = 3'd1,
    parameter logic [2:0] CLASS_B_TDEST = 3'd2,
    parameter int         CREDIT_W      = 32
) (
`ifdef CBS_STATS_EN
    output logic [31:0] stall_cycles_a,
    output logic [31:0] stall_cycles_b,
`endif
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] rx_axis_tdata,
    input  logic [7:0]  rx_axis_tkeep,
    input  logic        rx_axis_tlast,
    input  logic        rx_axis_tvalid,
    output logic        rx_axis_tready,
    input  logic [2:0]  rx_axis_tdest,
    input  logic [10:0] frame_len_in,
    input  logic [11:0] gate_id_in,
    input  logic [15:0] idle_slope_a,
    input  logic [15:0] idle_slope_b,
    output logic [63:0] tx_axis_tdata,
    output logic [7:0]  tx_axis_tkeep,
    output logic        tx_axis_tlast,
    output logic        tx_axis_tvalid,
    input  logic        tx_axis_tready,
    output logic [2:0]  tx_axis_tdest,
    output logic [10:0] frame_len_out,
    output logic [11:0] gate_id_out
);

    typedef enum logic [1:0] {IDLE, HOLD, SEND} state_t;

    localparam int SUM_W = CREDIT_W + 2;
    localparam logic signed [SUM_W-1:0] SAT_HI   = $signed({3'b000, 1'b1, {(CREDIT_W-2){1'b0}}});
    localparam logic signed [SUM_W-1:0] SAT_LO   = -SAT_HI;
    localparam logic signed [SUM_W-1:0] SUM_ZERO = '0;

    state_t state, state_next;

    logic signed [CREDIT_W-1:0] credit_a, credit_b;
    logic [2:0] beat_dest;
    logic [3:0] beat_bytes;
    logic first_beat, head_a, head_b, eligible, gate_open, accept;
    logic send_a, send_b, hold_a, hold_b, pend_a, pend_b;

    function automatic logic [3:0] popcount8(input logic [7:0] keep);
        logic [3:0] cnt;
        cnt = '0;
        for (int i = 0; i < 8; i++)
            cnt = cnt + {3'b000, keep[i]};
        return cnt;
    endfunction

    // One class's credit for the next cycle; the caller supplies that class's activity flags.
    function automatic logic signed [CREDIT_W-1:0] credit_step(
        input logic signed [CREDIT_W-1:0] credit,
        input logic [15:0] slope,
        input logic        sending,
        input logic        holding,
        input logic        pending,
        input logic [3:0]  bytes
    );
        logic signed [SUM_W-1:0] sum;
        logic negative, positive;
        negative = credit[CREDIT_W-1];
        positive = !negative && (credit != '0);
        sum = {{2{credit[CREDIT_W-1]}}, credit};
        if (sending || holding || negative)
            sum = sum + $signed({{(SUM_W-16){1'b0}}, slope});
        if (sending)
            sum = sum - $signed({{(SUM_W-12){1'b0}}, bytes, 8'h00});
        if (!pending && !sending && positive)
            sum = SUM_ZERO;
        else if (!sending && !holding && negative && (sum > SUM_ZERO))
            sum = SUM_ZERO;
        if (sum > SAT_HI)
            sum = SAT_HI;
        else if (sum < SAT_LO)
            sum = SAT_LO;
        return sum[CREDIT_W-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // A held head frame only leaves HOLD once its first beat is actually accepted.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept)
                    state_next = rx_axis_tlast ? IDLE : SEND;
                else if (rx_axis_tvalid && !eligible)
                    state_next = HOLD;
            end
            HOLD: begin
                if (!rx_axis_tvalid)
                    state_next = IDLE;
                else if (accept)
                    state_next = rx_axis_tlast ? IDLE : SEND;
            end
            SEND: begin
                if (accept && rx_axis_tlast)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        first_beat     = (state != SEND);
        beat_dest      = first_beat ? rx_axis_tdest : tx_axis_tdest;
        head_a         = (rx_axis_tdest == CLASS_A_TDEST);
        head_b         = (rx_axis_tdest == CLASS_B_TDEST);
        eligible       = !(head_a && credit_a[CREDIT_W-1]) && !(head_b && credit_b[CREDIT_W-1]);
        gate_open      = !rst && ((state == SEND) || (rx_axis_tvalid && eligible));
        rx_axis_tready = (!tx_axis_tvalid || tx_axis_tready) && gate_open;
        accept         = rx_axis_tvalid && rx_axis_tready;
        beat_bytes     = popcount8(rx_axis_tkeep);
        send_a         = accept && (beat_dest == CLASS_A_TDEST);
        send_b         = accept && (beat_dest == CLASS_B_TDEST);
        pend_a         = first_beat && rx_axis_tvalid && head_a;
        pend_b         = first_beat && rx_axis_tvalid && head_b;
        hold_a         = (state == HOLD) && pend_a;
        hold_b         = (state == HOLD) && pend_b;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            credit_a <= '0;
            credit_b <= '0;
        end else begin
            credit_a <= credit_step(credit_a, idle_slope_a, send_a, hold_a, pend_a, beat_bytes);
            credit_b <= credit_step(credit_b, idle_slope_b, send_b, hold_b, pend_b, beat_bytes);
        end
    end

    // Sideband is latched only on a frame's first beat so it stays put for the whole frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_axis_tdata  <= '0;
            tx_axis_tkeep  <= '0;
            tx_axis_tlast  <= 1'b0;
            tx_axis_tvalid <= 1'b0;
            tx_axis_tdest  <= '0;
            frame_len_out  <= '0;
            gate_id_out    <= '0;
        end else if (accept) begin
            tx_axis_tdata  <= rx_axis_tdata;
            tx_axis_tkeep  <= rx_axis_tkeep;
            tx_axis_tlast  <= rx_axis_tlast;
            tx_axis_tvalid <= 1'b1;
            if (first_beat) begin
                tx_axis_tdest <= rx_axis_tdest;
                frame_len_out <= frame_len_in;
                gate_id_out   <= gate_id_in;
            end
        end else if (tx_axis_tready) begin
            tx_axis_tvalid <= 1'b0;
        end
    end

`ifdef CBS_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_a <= '0;
            stall_cycles_b <= '0;
        end else begin
            if (hold_a)
                stall_cycles_a <= stall_cycles_a + 32'd1;
            if (hold_b)
                stall_cycles_b <= stall_cycles_b + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cbs_egress_shaper.sv
// Directed bench for cbs_egress_shaper: reset, unshaped flow, class A/B shaping, backpressure, mid-frame reset.
// Observed tx beats are packed as {data, keep, last, dest, len, gid}.
module tb_cbs_egress_shaper;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] rx_axis_tdata = '0;
    logic [7:0]  rx_axis_tkeep = '0;
    logic        rx_axis_tlast = 1'b0;
    logic        rx_axis_tvalid = 1'b0;
    logic        rx_axis_tready;
    logic [2:0]  rx_axis_tdest = '0;
    logic [10:0] frame_len_in = '0;
    logic [11:0] gate_id_in = '0;
    logic [15:0] idle_slope_a = '0;
    logic [15:0] idle_slope_b = '0;
    logic [63:0] tx_axis_tdata;
    logic [7:0]  tx_axis_tkeep;
    logic        tx_axis_tlast;
    logic        tx_axis_tvalid;
    logic        tx_axis_tready = 1'b1;
    logic [2:0]  tx_axis_tdest;
    logic [10:0] frame_len_out;
    logic [11:0] gate_id_out;
`ifdef CBS_STATS_EN
    logic [31:0] stall_cycles_a, stall_cycles_b;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int tready_mode = 0;

    typedef struct {
        logic [98:0] vec;
        int          cyc;
    } beat_t;
    beat_t txq[$];

    logic [98:0] tx_vec, held_vec;
    logic        held = 1'b0;

    cbs_egress_shaper dut (
`ifdef CBS_STATS_EN
        .stall_cycles_a(stall_cycles_a),
        .stall_cycles_b(stall_cycles_b),
`endif
        .clk(clk), .rst(rst),
        .rx_axis_tdata(rx_axis_tdata), .rx_axis_tkeep(rx_axis_tkeep),
        .rx_axis_tlast(rx_axis_tlast), .rx_axis_tvalid(rx_axis_tvalid),
        .rx_axis_tready(rx_axis_tready), .rx_axis_tdest(rx_axis_tdest),
        .frame_len_in(frame_len_in), .gate_id_in(gate_id_in),
        .idle_slope_a(idle_slope_a), .idle_slope_b(idle_slope_b),
        .tx_axis_tdata(tx_axis_tdata), .tx_axis_tkeep(tx_axis_tkeep),
        .tx_axis_tlast(tx_axis_tlast), .tx_axis_tvalid(tx_axis_tvalid),
        .tx_axis_tready(tx_axis_tready), .tx_axis_tdest(tx_axis_tdest),
        .frame_len_out(frame_len_out), .gate_id_out(gate_id_out)
    );

    assign tx_vec = {tx_axis_tdata, tx_axis_tkeep, tx_axis_tlast, tx_axis_tdest, frame_len_out, gate_id_out};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream ready: 0 = always ready, 1 = toggle every cycle, 2 = stalled.
    always @(posedge clk) begin
        #2;
        case (tready_mode)
            1:       tx_axis_tready = ~tx_axis_tready;
            2:       tx_axis_tready = 1'b0;
            default: tx_axis_tready = 1'b1;
        endcase
    end

    // Collect every tx handshake and require the slice to hold still while stalled.
    always @(negedge clk) begin
        if (held) begin
            total++;
            if (tx_vec !== held_vec || tx_axis_tvalid !== 1'b1) begin
                bad++;
                $display("FAIL tx_stable: got %h valid=%b, required %h valid=1", tx_vec, tx_axis_tvalid, held_vec);
            end
        end
        held     = tx_axis_tvalid && !tx_axis_tready;
        held_vec = tx_vec;
        if (tx_axis_tvalid && tx_axis_tready)
            txq.push_back('{vec: tx_vec, cyc: cyc});
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                              input logic [2:0] dest, input logic [10:0] len, input logic [11:0] gid,
                              output int acc_cyc);
        int guard;
        rx_axis_tdata  = d;
        rx_axis_tkeep  = k;
        rx_axis_tlast  = l;
        rx_axis_tdest  = dest;
        frame_len_in   = len;
        gate_id_in     = gid;
        rx_axis_tvalid = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!rx_axis_tready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            total++;
            bad++;
            $display("FAIL rx_accept: rx_axis_tready stayed 0 for %0d cycles, required 1", guard);
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
    endtask

    task automatic send_frame(input logic [2:0] dest, input logic [10:0] len, input logic [11:0] gid,
                              input int nbeats, input logic [7:0] last_keep, input logic [31:0] base,
                              output int first_cyc, output int last_cyc);
        int c;
        first_cyc = 0;
        last_cyc  = 0;
        for (int i = 0; i < nbeats; i++) begin
            drive_beat({base, 32'(i)}, (i == nbeats - 1) ? last_keep : 8'hFF, (i == nbeats - 1),
                       dest, len, gid, c);
            if (i == 0)
                first_cyc = c;
            last_cyc = c;
        end
        rx_axis_tvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx_axis_tvalid = 1'b1;
        idle(3);
        total++;
        if (rx_axis_tready !== 1'b0) begin
            bad++;
            $display("FAIL reset_rx_tready: got %b, required 0", rx_axis_tready);
        end
        total++;
        if (tx_axis_tvalid !== 1'b0 || tx_vec !== 99'd0) begin
            bad++;
            $display("FAIL reset_tx: got valid=%b vec=%h, required valid=0 vec=0", tx_axis_tvalid, tx_vec);
        end
        total++;
        if (dut.credit_a !== 32'sd0 || dut.credit_b !== 32'sd0) begin
            bad++;
            $display("FAIL reset_credit: got a=%0d b=%0d, required 0 0", dut.credit_a, dut.credit_b);
        end
        rx_axis_tvalid = 1'b0;
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_unshaped();
        int f, l;
        txq.delete();
        send_frame(3'd0, 11'd64, 12'h0AA, 8, 8'hFF, 32'h1000, f, l);
        idle(3);
        total++;
        if (txq.size() != 8) begin
            bad++;
            $display("FAIL unshaped_count: got %0d beats, required 8", txq.size());
        end
        for (int i = 0; i < 8 && i < txq.size(); i++) begin
            total++;
            if (txq[i].vec !== {32'h1000, 32'(i), 8'hFF, (i == 7), 3'd0, 11'd64, 12'h0AA} || txq[i].cyc != f + i) begin
                bad++;
                $display("FAIL unshaped_beat%0d: got %h at cycle %0d, required cycle %0d", i, txq[i].vec, txq[i].cyc, f + i);
            end
        end
        total++;
        if (dut.credit_a !== 32'sd0 || dut.credit_b !== 32'sd0) begin
            bad++;
            $display("FAIL unshaped_credit: got a=%0d b=%0d, required 0 0", dut.credit_a, dut.credit_b);
        end
    endtask

    task automatic test_back_to_back();
        int f1, l1, f2, l2;
`ifdef CBS_STATS_EN
        logic [31:0] stall0;
`endif
        txq.delete();
        idle_slope_a = 16'd512;
        idle(1);
        send_frame(3'd1, 11'd64, 12'h0A1, 8, 8'hFF, 32'h2000, f1, l1);
        total++;
        if (dut.credit_a !== -32'sd12288) begin
            bad++;
            $display("FAIL b2b_credit1: got %0d, required -12288", dut.credit_a);
        end
`ifdef CBS_STATS_EN
        stall0 = stall_cycles_a;
`endif
        send_frame(3'd1, 11'd64, 12'h0A2, 8, 8'hFF, 32'h3000, f2, l2);
        total++;
        if (dut.credit_a !== -32'sd12288) begin
            bad++;
            $display("FAIL b2b_credit2: got %0d, required -12288", dut.credit_a);
        end
`ifdef CBS_STATS_EN
        total++;
        if (stall_cycles_a - stall0 != 32'd24) begin
            bad++;
            $display("FAIL b2b_stall: got %0d hold cycles, required 24", stall_cycles_a - stall0);
        end
`endif
        idle(3);
        total++;
        if (txq.size() != 16) begin
            bad++;
            $display("FAIL b2b_count: got %0d beats, required 16", txq.size());
        end else begin
            // 24 empty tx cycles between frame 1's tlast and frame 2's first beat
            total++;
            if (txq[8].cyc - txq[7].cyc != 25) begin
                bad++;
                $display("FAIL b2b_gap: got %0d cycles, required 25", txq[8].cyc - txq[7].cyc);
            end
            total++;
            if (txq[8].vec !== {32'h3000, 32'd0, 8'hFF, 1'b0, 3'd1, 11'd64, 12'h0A2}) begin
                bad++;
                $display("FAIL b2b_frame2_head: got %h", txq[8].vec);
            end
        end
        idle(30);
        total++;
        if (dut.credit_a !== 32'sd0) begin
            bad++;
            $display("FAIL b2b_recover: got %0d, required 0", dut.credit_a);
        end
    endtask

    task automatic test_positive_credit_reset();
        int c;
`ifdef CBS_STATS_EN
        logic [31:0] stall0;
`endif
        tready_mode = 2;
        idle(1);
        drive_beat({32'h2222, 32'd0}, 8'hFF, 1'b1, 3'd1, 11'd8, 12'h0B0, c);
        rx_axis_tvalid = 1'b0;
        total++;
        if (dut.credit_a !== -32'sd1536) begin
            bad++;
            $display("FAIL pos_single_charge: got %0d, required -1536", dut.credit_a);
        end
`ifdef CBS_STATS_EN
        stall0 = stall_cycles_a;
`endif
        rx_axis_tdata  = 64'h0;
        rx_axis_tkeep  = 8'hFF;
        rx_axis_tlast  = 1'b0;
        rx_axis_tdest  = 3'd1;
        rx_axis_tvalid = 1'b1;
        idle(5);
        total++;
        if (dut.credit_a !== 32'sd1024 || rx_axis_tready !== 1'b0) begin
            bad++;
            $display("FAIL pos_credit: got %0d ready=%b, required 1024 ready=0", dut.credit_a, rx_axis_tready);
        end
        rx_axis_tvalid = 1'b0;
        idle(1);
        total++;
        if (dut.credit_a !== 32'sd0) begin
            bad++;
            $display("FAIL pos_zeroed: got %0d, required 0", dut.credit_a);
        end
`ifdef CBS_STATS_EN
        total++;
        if (stall_cycles_a - stall0 != 32'd4) begin
            bad++;
            $display("FAIL pos_stall: got %0d hold cycles, required 4", stall_cycles_a - stall0);
        end
`endif
        tready_mode = 0;
        idle(3);
    endtask

    task automatic test_backpressure();
        int f, l;
        txq.delete();
        idle_slope_b = 16'd0;
        tready_mode = 1;
        send_frame(3'd2, 11'd32, 12'h0B2, 4, 8'hFF, 32'h4000, f, l);
        idle(6);
        tready_mode = 0;
        idle(3);
        total++;
        if (txq.size() != 4) begin
            bad++;
            $display("FAIL bp_count: got %0d beats, required 4", txq.size());
        end
        for (int i = 0; i < 4 && i < txq.size(); i++) begin
            total++;
            if (txq[i].vec !== {32'h4000, 32'(i), 8'hFF, (i == 3), 3'd2, 11'd32, 12'h0B2}) begin
                bad++;
                $display("FAIL bp_beat%0d: got %h", i, txq[i].vec);
            end
        end
        total++;
        if (dut.credit_b !== -32'sd8192) begin
            bad++;
            $display("FAIL bp_credit: got %0d, required -8192", dut.credit_b);
        end
    endtask

    task automatic test_partial_last();
        int f, l;
        txq.delete();
        send_frame(3'd1, 11'd60, 12'h0C3, 8, 8'h0F, 32'h5000, f, l);
        total++;
        if (dut.credit_a !== -32'sd11264) begin
            bad++;
            $display("FAIL partial_credit: got %0d, required -11264", dut.credit_a);
        end
        idle(2);
        total++;
        if (txq.size() != 8 || txq[txq.size()-1].vec !== {32'h5000, 32'd7, 8'h0F, 1'b1, 3'd1, 11'd60, 12'h0C3}) begin
            bad++;
            $display("FAIL partial_last_beat: got %0d beats, last %h", txq.size(), txq[txq.size()-1].vec);
        end
    endtask

    task automatic test_reset_mid_frame();
        int c, f, l;
        txq.delete();
        for (int i = 0; i < 3; i++)
            drive_beat({32'h7000, 32'(i)}, 8'hFF, 1'b0, 3'd5, 11'd64, 12'h055, c);
        rx_axis_tdata = {32'h7000, 32'd3};
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        rx_axis_tvalid = 1'b0;
        total++;
        if (tx_axis_tvalid !== 1'b0 || tx_vec !== 99'd0) begin
            bad++;
            $display("FAIL midrst_tx: got valid=%b vec=%h, required valid=0 vec=0", tx_axis_tvalid, tx_vec);
        end
        total++;
        if (dut.credit_a !== 32'sd0 || dut.credit_b !== 32'sd0) begin
            bad++;
            $display("FAIL midrst_credit: got a=%0d b=%0d, required 0 0", dut.credit_a, dut.credit_b);
        end
        send_frame(3'd2, 11'd77, 12'h321, 1, 8'h01, 32'h6000, f, l);
        total++;
        if (dut.credit_b !== -32'sd256) begin
            bad++;
            $display("FAIL midrst_single_charge: got %0d, required -256", dut.credit_b);
        end
        idle(3);
        total++;
        if (txq.size() != 4) begin
            bad++;
            $display("FAIL midrst_count: got %0d beats, required 4", txq.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (txq[i].vec !== {32'h7000, 32'(i), 8'hFF, 1'b0, 3'd5, 11'd64, 12'h055}) begin
                    bad++;
                    $display("FAIL midrst_old%0d: got %h", i, txq[i].vec);
                end
            end
            total++;
            if (txq[3].vec !== {32'h6000, 32'd0, 8'h01, 1'b1, 3'd2, 11'd77, 12'h321}) begin
                bad++;
                $display("FAIL midrst_new_frame: got %h", txq[3].vec);
            end
        end
    endtask

    initial begin
        test_reset();
        test_unshaped();
        test_back_to_back();
        test_positive_credit_reset();
        test_backpressure();
        test_partial_last();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
